// File: rtl/pulse_meas_core.sv
// rtl/pulse_meas_core.sv - bus-mapped pulse delay/width/period/count measurement core
// PULSE_IN and EXT_START are synchronized and edge-detected before driving the measurement FSM.
module pulse_meas_core #(
    parameter int unsigned ABUSWIDTH  = 16,
    parameter logic [7:0]  VERSION_ID = 8'd1
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_WR,
    input  logic                 BUS_RD,
    input  logic                 EXT_START,
    input  logic                 PULSE_IN,
    output logic                 BUSY
);

    typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic        conf_en_q, conf_en_d;
    logic [31:0] conf_repeat_q, conf_repeat_d;
    logic [31:0] conf_timeout_q, conf_timeout_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] width_q, width_d;
    logic [31:0] period_q, period_d;
    logic [31:0] pulse_cnt_q, pulse_cnt_d;
    logic [31:0] t_q, t_d;
    logic [31:0] w_cnt_q, w_cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [2:0]  pulse_sync_q, pulse_sync_d;
    logic [2:0]  ext_sync_q, ext_sync_d;

    logic        rise, fall, ext_rise, start, soft_rst, arm, timeout_hit;
    logic [31:0] t_inc, w_cnt_inc, cnt_inc, eff_repeat;
    logic [1:0]  byte_idx;
    logic [7:0]  rd_mux;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] v, input logic [1:0] idx);
        logic [31:0] sh;
        sh = v >> {idx, 3'b000};
        return sh[7:0];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] v, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] mask;
        mask = 32'h0000_00FF << {idx, 3'b000};
        return (v & ~mask) | ({24'd0, b} << {idx, 3'b000});
    endfunction

    function automatic logic addr_in(input logic [ABUSWIDTH-1:0] a, input int unsigned lo,
                                     input int unsigned hi);
        return (a >= ABUSWIDTH'(lo)) && (a <= ABUSWIDTH'(hi));
    endfunction

    // bit 0 = metastable stage, bit 1 = synchronized level, bit 2 = edge register
    always_comb begin
        pulse_sync_d = {pulse_sync_q[1:0], PULSE_IN};
        ext_sync_d   = {ext_sync_q[1:0], EXT_START};
    end

    assign rise        = pulse_sync_q[1] & ~pulse_sync_q[2];
    assign fall        = ~pulse_sync_q[1] & pulse_sync_q[2];
    assign ext_rise    = ext_sync_q[1] & ~ext_sync_q[2];
    assign start       = BUS_WR && (BUS_ADD == ABUSWIDTH'(1));
    assign soft_rst    = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
    assign arm         = start | (ext_rise & conf_en_q);
    assign eff_repeat  = (conf_repeat_q == 32'd0) ? 32'd1 : conf_repeat_q;
    assign t_inc       = sat_inc(t_q);
    assign w_cnt_inc   = sat_inc(w_cnt_q);
    assign cnt_inc     = sat_inc(pulse_cnt_q);
    assign timeout_hit = (conf_timeout_q != 32'd0) && (t_inc >= conf_timeout_q);
    // every 32-bit field starts at an address that is 3 mod 4
    assign byte_idx    = BUS_ADD[1:0] + 2'd1;
    assign BUSY        = (state_q != IDLE);
    assign BUS_DATA_OUT = rdata_q;

    always_comb begin
        rd_mux = 8'd0;
        if (BUS_ADD == ABUSWIDTH'(0))      rd_mux = VERSION_ID;
        else if (BUS_ADD == ABUSWIDTH'(1)) rd_mux = {6'd0, timeout_q, done_q};
        else if (BUS_ADD == ABUSWIDTH'(2)) rd_mux = {7'd0, conf_en_q};
        else if (addr_in(BUS_ADD, 3, 6))   rd_mux = get_byte(conf_repeat_q, byte_idx);
        else if (addr_in(BUS_ADD, 7, 10))  rd_mux = get_byte(conf_timeout_q, byte_idx);
        else if (addr_in(BUS_ADD, 11, 14)) rd_mux = get_byte(delay_q, byte_idx);
        else if (addr_in(BUS_ADD, 15, 18)) rd_mux = get_byte(width_q, byte_idx);
        else if (addr_in(BUS_ADD, 19, 22)) rd_mux = get_byte(period_q, byte_idx);
        else if (addr_in(BUS_ADD, 23, 26)) rd_mux = get_byte(pulse_cnt_q, byte_idx);
        rdata_d = BUS_RD ? rd_mux : rdata_q;
    end

    always_comb begin
        state_d        = state_q;
        done_d         = done_q;
        timeout_d      = timeout_q;
        conf_en_d      = conf_en_q;
        conf_repeat_d  = conf_repeat_q;
        conf_timeout_d = conf_timeout_q;
        delay_d        = delay_q;
        width_d        = width_q;
        period_d       = period_q;
        pulse_cnt_d    = pulse_cnt_q;
        t_d            = t_q;
        w_cnt_d        = w_cnt_q;

        if (BUS_WR) begin
            if (BUS_ADD == ABUSWIDTH'(2)) conf_en_d = BUS_DATA_IN[0];
            if (addr_in(BUS_ADD, 3, 6))  conf_repeat_d  = set_byte(conf_repeat_q, byte_idx, BUS_DATA_IN);
            if (addr_in(BUS_ADD, 7, 10)) conf_timeout_d = set_byte(conf_timeout_q, byte_idx, BUS_DATA_IN);
        end

        if (soft_rst) begin
            state_d        = IDLE;
            done_d         = 1'b1;
            timeout_d      = 1'b0;
            conf_en_d      = 1'b0;
            conf_repeat_d  = 32'd1;
            conf_timeout_d = 32'd0;
            delay_d        = 32'd0;
            width_d        = 32'd0;
            period_d       = 32'd0;
            pulse_cnt_d    = 32'd0;
            t_d            = 32'd0;
            w_cnt_d        = 32'd0;
        end else if (arm) begin
            state_d     = WAIT_RISE;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
            delay_d     = 32'd0;
            width_d     = 32'd0;
            period_d    = 32'd0;
            pulse_cnt_d = 32'd0;
            t_d         = 32'd0;
            w_cnt_d     = 32'd0;
        end else if (state_q != IDLE) begin
            t_d = t_inc;
            // a timeout drops any edge seen in the same cycle
            if (timeout_hit) begin
                state_d   = IDLE;
                done_d    = 1'b1;
                timeout_d = 1'b1;
            end else begin
                if (state_q == HIGH) w_cnt_d = w_cnt_inc;
                if (rise) begin
                    pulse_cnt_d = cnt_inc;
                    w_cnt_d     = 32'd0;
                    if (pulse_cnt_q == 32'd0) delay_d  = t_q;
                    if (pulse_cnt_q == 32'd1) period_d = t_q - delay_q;
                    state_d = HIGH;
                end else if (fall && (state_q == HIGH)) begin
                    if (pulse_cnt_q == 32'd1) width_d = w_cnt_inc;
                    if (pulse_cnt_q == eff_repeat) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        timeout_d = 1'b0;
                    end else begin
                        state_d = LOW;
                    end
                end
            end
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state_q        <= IDLE;
            done_q         <= 1'b1;
            timeout_q      <= 1'b0;
            conf_en_q      <= 1'b0;
            conf_repeat_q  <= 32'd1;
            conf_timeout_q <= 32'd0;
            delay_q        <= 32'd0;
            width_q        <= 32'd0;
            period_q       <= 32'd0;
            pulse_cnt_q    <= 32'd0;
            t_q            <= 32'd0;
            w_cnt_q        <= 32'd0;
            rdata_q        <= 8'd0;
            pulse_sync_q   <= 3'd0;
            ext_sync_q     <= 3'd0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            timeout_q      <= timeout_d;
            conf_en_q      <= conf_en_d;
            conf_repeat_q  <= conf_repeat_d;
            conf_timeout_q <= conf_timeout_d;
            delay_q        <= delay_d;
            width_q        <= width_d;
            period_q       <= period_d;
            pulse_cnt_q    <= pulse_cnt_d;
            t_q            <= t_d;
            w_cnt_q        <= w_cnt_d;
            rdata_q        <= rdata_d;
            pulse_sync_q   <= pulse_sync_d;
            ext_sync_q     <= ext_sync_d;
        end
    end

endmodule

// File: tb/tb_pulse_meas_core.sv
// tb/tb_pulse_meas_core.sv - self-checking bench for pulse_meas_core
module tb_pulse_meas_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus_add = 16'd0;
    logic [7:0]  bus_din = 8'd0;
    logic [7:0]  bus_dout;
    logic        bus_wr = 1'b0;
    logic        bus_rd = 1'b0;
    logic        ext_start = 1'b0;
    logic        pulse_in = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;
    bit seq[$];

    pulse_meas_core #(.ABUSWIDTH(16), .VERSION_ID(8'd1)) dut (
        .BUS_CLK(clk), .BUS_RST_N(rst_n), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din),
        .BUS_DATA_OUT(bus_dout), .BUS_WR(bus_wr), .BUS_RD(bus_rd),
        .EXT_START(ext_start), .PULSE_IN(pulse_in), .BUSY(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct { int addr; int exp; } rd_vec_t;
    typedef struct {
        int rep; int tmo; int n; int hi; int lo; int np;
        int e_dly; int e_wid; int e_per; int e_cnt; int e_st;
    } dir_t;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        bus_add = 16'(a);
        bus_din = 8'(d);
        bus_wr  = 1'b1;
        tick();
        bus_wr  = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        bus_add = 16'(a);
        bus_rd  = 1'b1;
        tick();
        bus_rd  = 1'b0;
        d = int'(bus_dout);
    endtask

    task automatic wr32(input int a, input longint v);
        for (int i = 0; i < 4; i++) wr(a + i, int'((v >> (8 * i)) & 255));
    endtask

    task automatic rd32(input int a, output longint v);
        int b;
        v = 0;
        for (int i = 0; i < 4; i++) begin
            rd(a + i, b);
            v = v | (longint'(b) << (8 * i));
        end
    endtask

    // START at edge 0 together with seq[0]; seq[k] is sampled at edge k
    task automatic run_seq();
        bus_add  = 16'd1;
        bus_wr   = 1'b1;
        pulse_in = seq[0];
        tick();
        bus_wr = 1'b0;
        for (int k = 1; k < seq.size(); k++) begin
            pulse_in = seq[k];
            tick();
        end
        pulse_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_results(input string tag, input int dly, input int wid, input int per,
                                 input int cnt, input int st, input int bsy);
        longint v;
        int s;
        rd32(11, v); check({tag, " delay"}, v, dly);
        rd32(15, v); check({tag, " width"}, v, wid);
        rd32(19, v); check({tag, " period"}, v, per);
        rd32(23, v); check({tag, " pulse_cnt"}, v, cnt);
        rd(1, s);    check({tag, " status"}, s, st);
        check({tag, " busy"}, busy, bsy);
    endtask

    function automatic int samp(input int i);
        if (i < 0 || i >= seq.size()) return 0;
        return int'(seq[i]);
    endfunction

    // Edge-indexed reference: a level change sampled at edge k is acted on at edge k+2,
    // where the timer reads k+1; the timeout fires at the edge where the timer becomes tmo.
    function automatic void model(input int rep, input int tmo, output int dly, output int wid,
                                  output int per, output int cnt, output int st, output int bsy);
        int eff, phase, r1, k;
        eff = (rep == 0) ? 1 : rep;
        dly = 0; wid = 0; per = 0; cnt = 0; st = 0; bsy = 1; phase = 0; r1 = 0;
        for (int e = 1; e < seq.size() + 40 && bsy == 1; e++) begin
            if (tmo != 0 && e >= tmo) begin
                bsy = 0;
                st = 3;
            end else if (e >= 2) begin
                k = e - 2;
                if (samp(k) == 1 && samp(k - 1) == 0) begin
                    cnt++;
                    if (cnt == 1) begin dly = k + 1; r1 = k; end
                    else if (cnt == 2) per = k - r1;
                    phase = 1;
                end else if (samp(k) == 0 && samp(k - 1) == 1 && phase == 1) begin
                    if (cnt == 1) wid = k - r1;
                    if (cnt == eff) begin bsy = 0; st = 1; end
                    else phase = 2;
                end
            end
        end
    endfunction

    initial begin
        rd_vec_t rv[$];
        dir_t    dv[6];
        int      d, n, lat, any, level, run;
        int      m_dly, m_wid, m_per, m_cnt, m_st, m_bsy, rep, tmo;
        longint  v;
        bit      found;

        for (int a = 0; a < 28; a++)
            rv.push_back('{a, (a == 0 || a == 1 || a == 3) ? 1 : 0});
        rv.push_back('{200, 0});
        rv.push_back('{16'hFFFF, 0});

        dv[0] = '{1, 0, 10, 5, 5, 1,  11, 5, 0, 1, 1};
        dv[1] = '{3, 0, 3, 4, 6, 3,   4, 4, 10, 3, 1};
        dv[2] = '{0, 0, 0, 1, 3, 1,   1, 1, 0, 1, 1};
        dv[3] = '{2, 0, 5, 3, 2, 4,   6, 3, 5, 2, 1};
        dv[4] = '{1, 12, 10, 20, 1, 1, 0, 0, 0, 0, 3};
        dv[5] = '{1, 12, 9, 20, 1, 1,  10, 0, 0, 1, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset dout", bus_dout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (rv[i]) begin
            rd(rv[i].addr, d);
            check($sformatf("reset read addr %0d", rv[i].addr), d, rv[i].exp);
        end
        check("idle busy", busy, 0);

        foreach (dv[i]) begin
            wr32(3, dv[i].rep);
            wr32(7, dv[i].tmo);
            seq.delete();
            for (int k = 0; k < dv[i].n + dv[i].np * (dv[i].hi + dv[i].lo) + 2; k++)
                seq.push_back(k >= dv[i].n && ((k - dv[i].n) % (dv[i].hi + dv[i].lo)) < dv[i].hi
                              && ((k - dv[i].n) / (dv[i].hi + dv[i].lo)) < dv[i].np);
            run_seq();
            check_results($sformatf("dir%0d", i), dv[i].e_dly, dv[i].e_wid, dv[i].e_per,
                          dv[i].e_cnt, dv[i].e_st, 0);
        end

        wr32(3, 1);
        wr32(7, 20);
        bus_add = 16'd1; bus_wr = 1'b1;
        tick();
        bus_wr = 1'b0;
        n = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            n++;
            tick();
        end
        check("timeout busy cycles", n, 20);
        rd(1, d);    check("timeout status", d, 3);
        rd32(11, v); check("timeout delay", v, 0);
        wr32(7, 0);

        wr(0, 0);
        wr(2, 0);
        any = 0;
        ext_start = 1'b1;
        repeat (4) begin tick(); if (busy) any = 1; end
        ext_start = 1'b0;
        repeat (4) begin tick(); if (busy) any = 1; end
        check("ext disabled no arm", any, 0);
        wr(2, 1);
        ext_start = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            lat++;
            if (busy) found = 1'b1;
        end
        ext_start = 1'b0;
        check("ext enabled arm", found, 1);
        check("ext arm latency", lat, 3);
        pulse_in = 1'b1;
        repeat (6) tick();
        wr(1, 0);
        rd32(11, v); check("restart delay cleared", v, 0);
        rd32(23, v); check("restart cnt cleared", v, 0);
        rd(1, d);    check("restart status", d, 0);
        check("restart busy", busy, 1);
        pulse_in = 1'b0; repeat (4) tick();
        pulse_in = 1'b1; repeat (3) tick();
        pulse_in = 1'b0; repeat (5) tick();
        rd32(23, v); check("restart final cnt", v, 1);
        rd32(15, v); check("restart final width", v, 3);
        rd(1, d);    check("restart final status", d, 1);
        check("restart final busy", busy, 0);
        wr(2, 0);

        for (int it = 0; it < 30; it++) begin
            rep = $urandom_range(0, 3);
            tmo = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(5, 140);
            wr32(3, rep);
            wr32(7, tmo);
            seq.delete();
            level = 0;
            while (seq.size() < 160) begin
                run = $urandom_range(1, 8);
                for (int j = 0; j < run && seq.size() < 160; j++) seq.push_back(level[0]);
                level = 1 - level;
            end
            run_seq();
            model(rep, tmo, m_dly, m_wid, m_per, m_cnt, m_st, m_bsy);
            check_results($sformatf("rand%0d rep=%0d tmo=%0d", it, rep, tmo),
                          m_dly, m_wid, m_per, m_cnt, m_st, m_bsy);
        end

        wr32(3, 1);
        wr32(7, 0);
        wr(1, 0);
        pulse_in = 1'b1;
        repeat (5) tick();
        rd(0, d);
        check("pre-reset read", d, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset dout", bus_dout, 0);
        pulse_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_add = 16'd1; bus_wr = 1'b1;
        tick();
        bus_wr = 1'b0;
        check("arm first edge after reset", busy, 1);
        rd(1, d); check("status after rearm", d, 0);
        wr(3, 5);
        rd(3, d); check("conf repeat written", d, 5);
        wr(0, 0);
        rd(3, d); check("soft reset conf repeat", d, 1);
        rd(1, d); check("soft reset status", d, 1);
        check("soft reset busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
